// File: rtl/matrix_result_serializer.sv
// Output side of the matrix multiplier: snapshots the result matrix on a rising
// done and streams it as header, row-major element bytes and checksum over valid/ready.
module matrix_result_serializer #(
    parameter int         N           = 10,
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter bit         SEND_HEADER = 1'b1,
    parameter bit         SEND_CSUM   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*N*8-1:0] C_in,
    input  logic             done_in,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);

    localparam int NN = N * N;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HEADER = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CSUM   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]    state;
    logic          done_q;
    logic [IW-1:0] idx;
    logic [7:0]    csum;
    logic [7:0]    snap [NN];
    logic          rise;
    logic          xfer;

    assign rise = done_in & ~done_q;

    // Outputs decode straight from the state register, so tx_ready never reaches tx_valid.
    assign tx_valid   = (state == S_HEADER) || (state == S_DATA) || (state == S_CSUM);
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_FINISH);
    assign xfer       = tx_valid && tx_ready;

    // NOTE: every output of a combinational block gets a default first, otherwise
    // an uncovered case infers a latch.
    always_comb begin
        tx_data = 8'h00;
        case (state)
            S_HEADER: tx_data = HEADER;
            S_DATA:   tx_data = snap[idx];
            S_CSUM:   tx_data = csum;
            default:  tx_data = 8'h00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            done_q  <= 1'b0;
            idx     <= '0;
            csum    <= 8'h00;
            overrun <= 1'b0;
        end else begin
            done_q  <= done_in;
            // A rising done outside IDLE (FINISH included) is dropped, only flagged.
            overrun <= rise && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        csum  <= 8'h00;
                        idx   <= '0;
                        state <= SEND_HEADER ? S_HEADER : S_DATA;
                    end
                end
                S_HEADER: begin
                    if (xfer) begin
                        idx   <= '0;
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        csum <= csum + tx_data;
                        if (idx == IW'(NN - 1)) begin
                            idx   <= '0;
                            state <= SEND_CSUM ? S_CSUM : S_FINISH;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer) state <= S_FINISH;
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the snapshot array is deliberately left out of reset; it is always
    // loaded before any byte of it can be presented.
    always_ff @(posedge clk) begin
        if (rst && (state == S_IDLE) && rise) begin
            for (int k = 0; k < NN; k++) snap[k] <= C_in[k*8 +: 8];
        end
    end

endmodule

// File: doc/matrix_result_serializer.md
Name: matrix_result_serializer

Overview:
- Output side of the 10x10 matrix multiplier.
- Snapshots the flattened 8-bit result matrix when the multiplier's done rises, then streams it out byte-by-byte over a valid/ready byte interface toward the UART transmitter.
- Frame format: optional header byte, N*N element bytes in row-major order, optional 8-bit checksum.

Parameters:
- N, 10, matrix dimension; frame carries N*N element bytes; element width fixed at 8 bits.
- HEADER, 8'hA5, header byte value.
- SEND_HEADER, 1, 1 = emit HEADER before the data bytes.
- SEND_CSUM, 1, 1 = emit checksum byte after the data bytes.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low (rst==0 resets on the clk edge).
- C_in  input  N*N*8  flattened result matrix; element (i,j) at bits [(i*N+j)*8 +: 8].
- done_in  input  1  multiplier done; level signal, may stay high indefinitely.
- tx_data  output  8  byte to transmit.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  sink accepts the byte this cycle.
- busy  output  1  frame capture or transmission in progress.
- frame_done  output  1  one-cycle pulse after the last byte of a frame is accepted.
- overrun  output  1  one-cycle pulse when a done rising edge arrives while busy.

Behaviour:
- Reset (rst==0 at an edge):
  - tx_valid=0, tx_data=0, busy=0, frame_done=0, overrun=0.
  - done_q=0, byte index=0, checksum=0, state=IDLE.
  - Reset mid-frame abandons the frame; tx_valid is low from the next cycle.
- Trigger: rising edge of done_in, i.e. done_in==1 and registered done_q==0 at a clk edge. done_q is updated every cycle in every state.
- done_in held high never retriggers. A new frame needs done_in to fall and rise again.
- At the trigger edge in IDLE:
  - Copy C_in into an internal N*N*8 snapshot register.
  - Clear the checksum; go to HEADER if SEND_HEADER, else DATA.
  - busy=1 and tx_valid=1 from the next cycle, so the first byte is presented 1 cycle after the trigger edge.
  - Later changes on C_in do not affect the frame.
- Handshake:
  - A transfer occurs on any edge where tx_valid && tx_ready.
  - While tx_valid && !tx_ready, tx_data and tx_valid hold stable.
  - tx_valid never drops without a transfer, except on reset.
  - tx_ready may be high before tx_valid; no combinational path from tx_ready to tx_valid.
- States:
  - IDLE: tx_valid=0, busy=0.
  - HEADER: tx_data=HEADER. On transfer go to DATA, idx=0.
  - DATA: tx_data = snapshot element idx (idx=i*N+j, element 0 first). On transfer: checksum += byte mod 256, idx++. If idx==N*N-1, go to CSUM if SEND_CSUM, else FINISH.
  - CSUM: tx_data = checksum (sum of data bytes only, header excluded, mod 256). On transfer go to FINISH.
  - FINISH: lasts one cycle. frame_done=1, tx_valid=0, busy=1. Then IDLE.
- Throughput: with tx_ready held high, one byte per cycle. Frame length = N*N + SEND_HEADER + SEND_CSUM bytes.
- Overrun: a done rising edge in any state other than IDLE is dropped, not queued. overrun pulses for 1 cycle and the current frame continues unaffected.
- A rising edge in the FINISH cycle is also dropped with an overrun pulse.
- Widths: idx is wide enough for N*N-1; checksum is an 8-bit wrapping accumulator.

Test Plan:
- Basic frame: C_in element e = e (0..99), done_in 0->1, tx_ready=1 -> bytes A5, 00, 01, ..., 63, 56 on 102 consecutive cycles starting 1 cycle after the trigger. Then frame_done pulses once, busy falls.
- Backpressure: same C_in, tx_ready toggled pseudo-randomly -> identical byte sequence; tx_data stable during every stalled cycle; no byte duplicated or lost.
- Snapshot integrity: all elements = 8'hFF at trigger, C_in changed to all 8'h11 on the next cycle -> 100 data bytes all FF; checksum = (100*255) mod 256 = 0x9C.
- Retrigger rules:
  - done_in held high after the frame -> no second frame.
  - done_in pulses low and high mid-frame -> overrun pulses once; the frame completes normally.
  - A later clean rising edge in IDLE -> new frame.
- Reset mid-frame: rst=0 for one cycle after 40 data bytes -> tx_valid=0 and busy=0 next cycle. A subsequent trigger restarts from the header with checksum reset.
- Parameter variant: SEND_HEADER=0, SEND_CSUM=0, N=2, elements 01,02,03,04 -> exactly 4 bytes 01,02,03,04, then frame_done.
